// File: rtl/dcache_dm_ctrl.sv
// dcache_dm_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller between a single-cycle core and a word-wide req/ack memory.
//
// Ports:
//   clk, RST             clock (rising edge), asynchronous active-high reset
//   MemRead, MemWrite    core load/store requests, held while stall=1
//   WA, Data_in          core byte address and store data
//   Data_out, stall      combinational load data and core freeze
//   mem_req, mem_we      backing-memory request and direction (1 = write)
//   mem_addr, mem_wdata  word-aligned byte address and write data (0 when idle)
//   mem_rdata, mem_ack   read data and transfer acknowledge
//   hit_cnt, miss_cnt    saturating load hit/miss counters
//
// Handshake: a backing-memory transfer completes on the rising edge where
// mem_req && mem_ack; mem_req, mem_we, mem_addr and mem_wdata hold steady
// until that edge, and mem_req only rises in REFILL or WRITE.
module dcache_dm_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LINES  = 8,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int WA_W  = ADDR_W - 2;
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;
  state_t state, state_nx;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS];

  logic [OFF_W-1:0]  cnt;
  logic [WA_W-1:0]   lat_waddr;   // word address of the pending miss or store
  logic [DATA_W-1:0] lat_data;
  logic              wr_done;
  logic              just_filled;

  // Byte-offset bits are never used; words are always aligned.
  logic unused_wa;
  assign unused_wa = ^WA[1:0];

  // Core-side address decode.
  logic [TAG_W-1:0] wa_tag;
  logic [IDX_W-1:0] wa_idx;
  logic [OFF_W-1:0] wa_off;
  logic             hit;
  assign wa_tag = WA[ADDR_W-1 -: TAG_W];
  assign wa_idx = WA[2+OFF_W +: IDX_W];
  assign wa_off = WA[2 +: OFF_W];
  assign hit    = valid[wa_idx] && (tag_mem[wa_idx] == wa_tag);

  // Latched-address decode, used by refill and by the write-through update.
  logic [TAG_W-1:0] lt_tag;
  logic [IDX_W-1:0] lt_idx;
  logic [OFF_W-1:0] lt_off;
  logic             lat_hit;
  assign lt_tag  = lat_waddr[WA_W-1 -: TAG_W];
  assign lt_idx  = lat_waddr[OFF_W +: IDX_W];
  assign lt_off  = lat_waddr[0 +: OFF_W];
  assign lat_hit = valid[lt_idx] && (tag_mem[lt_idx] == lt_tag);

  logic idle, load_req, load_hit, load_miss, st_start, st_retire;
  logic refill_ack, refill_last, write_ack;
  assign idle        = (state == S_IDLE);
  assign load_req    = idle && MemRead && !MemWrite;
  assign load_hit    = load_req && hit;
  assign load_miss   = load_req && !hit;
  assign st_start    = idle && MemWrite && !wr_done;
  assign st_retire   = idle && MemWrite && wr_done;
  assign refill_ack  = (state == S_REFILL) && mem_ack;
  assign refill_last = refill_ack && (cnt == '1);
  assign write_ack   = (state == S_WRITE) && mem_ack;

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (st_start)       state_nx = S_WRITE;
        else if (load_miss) state_nx = S_REFILL;
      end
      S_REFILL: if (refill_last) state_nx = S_IDLE;
      S_WRITE:  if (write_ack)   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    Data_out  = '0;
    case (state)
      S_IDLE: begin
        if (MemWrite)     stall = !wr_done;
        else if (MemRead) stall = !hit;
        if (load_hit) Data_out = data_mem[{wa_idx, wa_off}];
      end
      S_REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {lat_waddr[WA_W-1:OFF_W], cnt, 2'b00};
      end
      S_WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {lat_waddr, 2'b00};
        mem_wdata = lat_data;
      end
      default: stall = 1'b0;
    endcase
  end

  // Control registers and statistics.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      valid       <= '0;
      cnt         <= '0;
      lat_waddr   <= '0;
      lat_data    <= '0;
      wr_done     <= 1'b0;
      just_filled <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      if (load_miss || st_start) lat_waddr <= WA[ADDR_W-1:2];
      if (st_start)  lat_data <= Data_in;
      if (load_miss) cnt <= '0;
      if (refill_ack) cnt <= cnt + 1'b1;
      if (refill_last) begin
        valid[lt_idx] <= 1'b1;
        just_filled   <= 1'b1;
      end
      if (write_ack) wr_done <= 1'b1;
      if (st_retire) wr_done <= 1'b0;
      // The retire after a refill is neither a hit nor a miss; any IDLE
      // request consumes the flag so it cannot suppress a later hit.
      if (idle && (MemRead || MemWrite)) just_filled <= 1'b0;
      if (load_hit && !just_filled && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
      if (load_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!RST) begin
      if (refill_ack)  data_mem[{lt_idx, cnt}] <= mem_rdata;
      if (refill_last) tag_mem[lt_idx] <= lt_tag;
      if (write_ack && lat_hit) data_mem[{lt_idx, lt_off}] <= lat_data;
    end
  end

endmodule

// File: tb/tb_dcache_dm_ctrl.sv
// tb_dcache_dm_ctrl: directed bench for dcache_dm_ctrl with a req/ack backing
// memory model whose contents are word(a) = 32'h1000_0000 + a unless stored.
module tb_dcache_dm_ctrl;

  logic        clk, RST, MemRead, MemWrite;
  logic [9:0]  WA;
  logic [31:0] Data_in, Data_out;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  hit_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;

  dcache_dm_ctrl #(.ADDR_W(10), .DATA_W(32), .LINES(8), .WORDS(4), .CNT_W(3)) dut (
    .clk(clk), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .WA(WA),
    .Data_in(Data_in), .Data_out(Data_out), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- backing memory model ----------------
  logic [31:0] bk [256];
  int ack_delay = 0;
  int wait_n = 0;

  initial begin
    for (int i = 0; i < 256; i++) bk[i] = 32'h1000_0000 + 32'(i * 4);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_n >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = bk[mem_addr[9:2]];
        if (mem_we) bk[mem_addr[9:2]] = mem_wdata;
        wait_n = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_n++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      wait_n    = 0;
    end
  end

  // ---------------- driver tasks ----------------
  logic [9:0] addr_q[$];   // observed mem_addr while mem_req=1
  logic [9:0] exp_q[$];    // expected mem_addr sequence
  logic       we_all;
  logic [31:0] wdata_seen;

  task automatic idle_cycle();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
  endtask

  // Holds a load until stall drops; returns stall cycles and retired data.
  task automatic drv_load(input logic [9:0] a, output int n, output logic [31:0] d);
    n = 0;
    addr_q.delete();
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; WA = a;
    #1;
    while (stall && n < 100) begin
      n++;
      if (mem_req) addr_q.push_back(mem_addr);
      @(negedge clk); #1;
    end
    d = Data_out;
  endtask

  task automatic drv_store(input logic [9:0] a, input logic [31:0] wd, output int n);
    n = 0;
    addr_q.delete();
    we_all = 1'b1;
    wdata_seen = '0;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; WA = a; Data_in = wd;
    #1;
    while (stall && n < 100) begin
      n++;
      if (mem_req) begin
        addr_q.push_back(mem_addr);
        we_all = we_all & mem_we;
        wdata_seen = mem_wdata;
      end
      @(negedge clk); #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; WA = '0; Data_in = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
    total++; if (Data_out !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", Data_out); end
    total++; if (mem_req !== 1'b0)   begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
    total++; if (mem_we !== 1'b0)    begin bad++; $display("FAIL rst_we got=%b want=0", mem_we); end
    total++; if (mem_addr !== 10'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
    total++; if (hit_cnt !== 3'd0)   begin bad++; $display("FAIL rst_hit got=%0d want=0", hit_cnt); end
    total++; if (miss_cnt !== 3'd0)  begin bad++; $display("FAIL rst_miss got=%0d want=0", miss_cnt); end
    @(negedge clk); RST = 1'b0;
    @(negedge clk); MemRead = 1'b1; WA = 10'h040;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL first_miss_stall got=%b want=1", stall); end
    @(negedge clk); #1;
    total++; if (miss_cnt !== 3'd1) begin bad++; $display("FAIL first_miss_cnt got=%0d want=1", miss_cnt); end
    total++; if (mem_addr !== 10'h040) begin bad++; $display("FAIL first_miss_addr got=%h want=040", mem_addr); end
    // Reset again mid-refill so the following scenario starts clean.
    RST = 1'b1; MemRead = 1'b0;
    #1;
    total++; if (miss_cnt !== 3'd0) begin bad++; $display("FAIL rerst_miss got=%0d want=0", miss_cnt); end
    @(negedge clk); RST = 1'b0;
  endtask

  task automatic test_refill();
    int n; logic [31:0] d;
    exp_q = '{10'h040, 10'h044, 10'h048, 10'h04C};
    drv_load(10'h044, n, d);
    total++; if (n != 5) begin bad++; $display("FAIL refill_stalls got=%0d want=5", n); end
    total++; if (d !== 32'h1000_0044) begin bad++; $display("FAIL refill_data got=%h want=10000044", d); end
    total++; if (addr_q.size() != 4) begin bad++; $display("FAIL refill_nreq got=%0d want=4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      total++;
      if (addr_q[i] !== exp_q[i]) begin bad++; $display("FAIL refill_addr%0d got=%h want=%h", i, addr_q[i], exp_q[i]); end
    end
    idle_cycle();
    total++; if (hit_cnt !== 3'd0)  begin bad++; $display("FAIL refill_hitcnt got=%0d want=0", hit_cnt); end
    total++; if (miss_cnt !== 3'd1) begin bad++; $display("FAIL refill_misscnt got=%0d want=1", miss_cnt); end
  endtask

  task automatic test_hits();
    int n; logic [31:0] d;
    drv_load(10'h040, n, d);
    total++; if (n != 0) begin bad++; $display("FAIL hit040_stalls got=%0d want=0", n); end
    total++; if (d !== 32'h1000_0040) begin bad++; $display("FAIL hit040_data got=%h want=10000040", d); end
    drv_load(10'h04C, n, d);
    total++; if (n != 0) begin bad++; $display("FAIL hit04c_stalls got=%0d want=0", n); end
    total++; if (d !== 32'h1000_004C) begin bad++; $display("FAIL hit04c_data got=%h want=1000004c", d); end
    idle_cycle();
    total++; if (hit_cnt !== 3'd2) begin bad++; $display("FAIL hits_cnt got=%0d want=2", hit_cnt); end
  endtask

  task automatic test_store_hit();
    int n; logic [31:0] d;
    ack_delay = 3;
    drv_store(10'h048, 32'hDEAD_BEEF, n);
    ack_delay = 0;
    total++; if (n != 5) begin bad++; $display("FAIL store_stalls got=%0d want=5", n); end
    total++; if (we_all !== 1'b1) begin bad++; $display("FAIL store_we got=%b want=1", we_all); end
    total++; if (wdata_seen !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_wdata got=%h want=deadbeef", wdata_seen); end
    total++; if (addr_q.size() != 4) begin bad++; $display("FAIL store_nreq got=%0d want=4", addr_q.size()); end
    foreach (addr_q[i]) begin
      total++;
      if (addr_q[i] !== 10'h048) begin bad++; $display("FAIL store_addr%0d got=%h want=048", i, addr_q[i]); end
    end
    idle_cycle();
    drv_load(10'h048, n, d);
    total++; if (n != 0) begin bad++; $display("FAIL store_rd_stalls got=%0d want=0", n); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_rd_data got=%h want=deadbeef", d); end
    idle_cycle();
    total++; if (hit_cnt !== 3'd3) begin bad++; $display("FAIL store_hitcnt got=%0d want=3", hit_cnt); end
  endtask

  task automatic test_no_allocate();
    int n; logic [31:0] d;
    drv_store(10'h200, 32'h1234_5678, n);
    total++; if (n != 2) begin bad++; $display("FAIL na_store_stalls got=%0d want=2", n); end
    idle_cycle();
    drv_load(10'h200, n, d);
    total++; if (n != 5) begin bad++; $display("FAIL na_load_stalls got=%0d want=5", n); end
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL na_load_data got=%h want=12345678", d); end
    idle_cycle();
    total++; if (miss_cnt !== 3'd2) begin bad++; $display("FAIL na_misscnt got=%0d want=2", miss_cnt); end
    total++; if (hit_cnt !== 3'd3)  begin bad++; $display("FAIL na_hitcnt got=%0d want=3", hit_cnt); end
  endtask

  task automatic test_evict();
    int n; logic [31:0] d;
    drv_load(10'h140, n, d);
    total++; if (n != 5) begin bad++; $display("FAIL ev140_stalls got=%0d want=5", n); end
    total++; if (d !== 32'h1000_0140) begin bad++; $display("FAIL ev140_data got=%h want=10000140", d); end
    drv_load(10'h040, n, d);
    total++; if (n != 5) begin bad++; $display("FAIL ev040_stalls got=%0d want=5", n); end
    total++; if (d !== 32'h1000_0040) begin bad++; $display("FAIL ev040_data got=%h want=10000040", d); end
    drv_load(10'h048, n, d);
    total++; if (n != 0) begin bad++; $display("FAIL ev048_stalls got=%0d want=0", n); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ev048_data got=%h want=deadbeef", d); end
    idle_cycle();
    total++; if (miss_cnt !== 3'd4) begin bad++; $display("FAIL ev_misscnt got=%0d want=4", miss_cnt); end
    total++; if (hit_cnt !== 3'd4)  begin bad++; $display("FAIL ev_hitcnt got=%0d want=4", hit_cnt); end
  endtask

  task automatic test_reset_refill();
    int n; logic [31:0] d;
    @(negedge clk); MemRead = 1'b1; WA = 10'h0C0;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rr_stall got=%b want=1", stall); end
    @(negedge clk); #1;
    total++; if (mem_addr !== 10'h0C0) begin bad++; $display("FAIL rr_w0 got=%h want=0c0", mem_addr); end
    @(negedge clk); #1;
    total++; if (mem_addr !== 10'h0C4) begin bad++; $display("FAIL rr_w1 got=%h want=0c4", mem_addr); end
    RST = 1'b1; MemRead = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rr_req got=%b want=0", mem_req); end
    total++; if (stall !== 1'b0)   begin bad++; $display("FAIL rr_stall_rst got=%b want=0", stall); end
    @(negedge clk); RST = 1'b0;
    exp_q = '{10'h0C0, 10'h0C4, 10'h0C8, 10'h0CC};
    drv_load(10'h0C0, n, d);
    total++; if (n != 5) begin bad++; $display("FAIL rr_stalls got=%0d want=5", n); end
    total++; if (d !== 32'h1000_00C0) begin bad++; $display("FAIL rr_data got=%h want=100000c0", d); end
    total++; if (addr_q.size() != 4) begin bad++; $display("FAIL rr_nreq got=%0d want=4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      total++;
      if (addr_q[i] !== exp_q[i]) begin bad++; $display("FAIL rr_addr%0d got=%h want=%h", i, addr_q[i], exp_q[i]); end
    end
    idle_cycle();
    total++; if (miss_cnt !== 3'd1) begin bad++; $display("FAIL rr_misscnt got=%0d want=1", miss_cnt); end
    total++; if (hit_cnt !== 3'd0)  begin bad++; $display("FAIL rr_hitcnt got=%0d want=0", hit_cnt); end
  endtask

  task automatic test_saturate();
    int n; logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      drv_load(10'h0C4, n, d);
      total++;
      if (n != 0 || d !== 32'h1000_00C4) begin
        bad++; $display("FAIL sat_load%0d got=%0d/%h want=0/100000c4", i, n, d);
      end
    end
    idle_cycle();
    total++; if (hit_cnt !== 3'd7)  begin bad++; $display("FAIL sat_hitcnt got=%0d want=7", hit_cnt); end
    total++; if (miss_cnt !== 3'd1) begin bad++; $display("FAIL sat_misscnt got=%0d want=1", miss_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_refill();
    test_hits();
    test_store_hit();
    test_no_allocate();
    test_evict();
    test_reset_refill();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
